// File: rtl/ex_stage.sv
// MIPS execute stage: MEM/WB operand forwarding, ALU, EX/MEM pipeline register.
// Latency 1 cycle; stall holds EX/MEM, flush or an invalid input loads a bubble (flush wins).
module ex_stage #(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_OP_ALU = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NB_OP_ALU-1:0] i_alu_op,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic [NB_REG-1:0]    i_shamt,
  input  logic                 i_alu_src,
  input  logic                 i_shift_src,
  input  logic [NB_REG-1:0]    i_rs_addr,
  input  logic [NB_REG-1:0]    i_rt_addr,
  input  logic [NB_REG-1:0]    i_rd_addr,
  input  logic                 i_reg_write,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_fwd_we,
  input  logic                 i_wb_fwd_we,
  input  logic [NB_REG-1:0]    i_mem_fwd_addr,
  input  logic [NB_REG-1:0]    i_wb_fwd_addr,
  input  logic [NB_DATA-1:0]   i_mem_fwd_data,
  input  logic [NB_DATA-1:0]   i_wb_fwd_data,
  output logic                 o_valid,
  output logic [NB_DATA-1:0]   o_alu_result,
  output logic [NB_DATA-1:0]   o_store_data,
  output logic [NB_REG-1:0]    o_rd_addr,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_zero
);

  localparam logic [NB_OP_ALU-1:0] OP_ADD  = 6'b100000;
  localparam logic [NB_OP_ALU-1:0] OP_SUB  = 6'b100010;
  localparam logic [NB_OP_ALU-1:0] OP_AND  = 6'b100100;
  localparam logic [NB_OP_ALU-1:0] OP_OR   = 6'b100101;
  localparam logic [NB_OP_ALU-1:0] OP_XOR  = 6'b100110;
  localparam logic [NB_OP_ALU-1:0] OP_NOR  = 6'b100111;
  localparam logic [NB_OP_ALU-1:0] OP_SLT  = 6'b101010;
  localparam logic [NB_OP_ALU-1:0] OP_SLL  = 6'b000000;
  localparam logic [NB_OP_ALU-1:0] OP_SLLV = 6'b000100;
  localparam logic [NB_OP_ALU-1:0] OP_SRL  = 6'b000010;
  localparam logic [NB_OP_ALU-1:0] OP_SRA  = 6'b000011;

  logic [NB_DATA-1:0] fwd_rs, fwd_rt, op_a, op_b, alu_res;
  logic [NB_REG-1:0]  shift_amt;

  logic               valid_q, valid_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic [NB_DATA-1:0] store_q, store_d;
  logic [NB_REG-1:0]  rd_q, rd_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               zero_q, zero_d;

  // MEM is the younger producer, so it takes priority; $zero is never forwarded.
  always_comb begin
    fwd_rs = i_rs_data;
    if (i_mem_fwd_we && (i_rs_addr != '0) && (i_mem_fwd_addr == i_rs_addr))
      fwd_rs = i_mem_fwd_data;
    else if (i_wb_fwd_we && (i_rs_addr != '0) && (i_wb_fwd_addr == i_rs_addr))
      fwd_rs = i_wb_fwd_data;
  end

  always_comb begin
    fwd_rt = i_rt_data;
    if (i_mem_fwd_we && (i_rt_addr != '0) && (i_mem_fwd_addr == i_rt_addr))
      fwd_rt = i_mem_fwd_data;
    else if (i_wb_fwd_we && (i_rt_addr != '0) && (i_wb_fwd_addr == i_rt_addr))
      fwd_rt = i_wb_fwd_data;
  end

  assign op_a      = fwd_rs;
  assign op_b      = i_alu_src ? i_imm : fwd_rt;
  assign shift_amt = i_shift_src ? fwd_rs[NB_REG-1:0] : i_shamt;

  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      OP_ADD:          alu_res = op_a + op_b;
      OP_SUB:          alu_res = op_a - op_b;
      OP_AND:          alu_res = op_a & op_b;
      OP_OR:           alu_res = op_a | op_b;
      OP_XOR:          alu_res = op_a ^ op_b;
      OP_NOR:          alu_res = ~(op_a | op_b);
      OP_SLT:          alu_res = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL, OP_SLLV: alu_res = fwd_rt << shift_amt;
      OP_SRL:          alu_res = fwd_rt >> shift_amt;
      OP_SRA:          alu_res = $signed(fwd_rt) >>> shift_amt;
      default:         alu_res = '0;
    endcase
  end

  // Value loaded when neither flushing nor stalling; an invalid slot becomes a bubble.
  always_comb begin
    valid_d     = 1'b0;
    result_d    = '0;
    store_d     = '0;
    rd_d        = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    zero_d      = 1'b0;
    if (i_valid) begin
      valid_d     = 1'b1;
      result_d    = alu_res;
      store_d     = fwd_rt;
      rd_d        = i_rd_addr;
      reg_write_d = i_reg_write;
      mem_read_d  = i_mem_read;
      mem_write_d = i_mem_write;
      zero_d      = (alu_res == '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      zero_q      <= 1'b0;
    end else if (i_flush) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      zero_q      <= 1'b0;
    end else if (!i_stall) begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      zero_q      <= zero_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_alu_result = result_q;
  assign o_store_data = store_q;
  assign o_rd_addr    = rd_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_read   = mem_read_q;
  assign o_mem_write  = mem_write_q;
  assign o_zero       = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: expected EX/MEM contents are queued when an instruction is driven
// and compared one cycle later, shortly after the rising edge.
module tb_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        zero;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  i_alu_op;
  logic        i_valid, i_stall, i_flush;
  logic [31:0] i_rs_data, i_rt_data, i_imm;
  logic [4:0]  i_shamt;
  logic        i_alu_src, i_shift_src;
  logic [4:0]  i_rs_addr, i_rt_addr, i_rd_addr;
  logic        i_reg_write, i_mem_read, i_mem_write;
  logic        i_mem_fwd_we, i_wb_fwd_we;
  logic [4:0]  i_mem_fwd_addr, i_wb_fwd_addr;
  logic [31:0] i_mem_fwd_data, i_wb_fwd_data;
  logic        o_valid;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write, o_mem_read, o_mem_write, o_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  ex_stage #(.NB_DATA(32), .NB_REG(5), .NB_OP_ALU(6)) dut (
    .clock(clock), .reset(reset), .i_alu_op(i_alu_op), .i_valid(i_valid),
    .i_stall(i_stall), .i_flush(i_flush), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm(i_imm), .i_shamt(i_shamt), .i_alu_src(i_alu_src), .i_shift_src(i_shift_src),
    .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_fwd_we(i_mem_fwd_we), .i_wb_fwd_we(i_wb_fwd_we),
    .i_mem_fwd_addr(i_mem_fwd_addr), .i_wb_fwd_addr(i_wb_fwd_addr),
    .i_mem_fwd_data(i_mem_fwd_data), .i_wb_fwd_data(i_wb_fwd_data),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_zero(o_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t get_obs();
    return '{o_valid, o_alu_result, o_store_data, o_rd_addr,
             o_reg_write, o_mem_read, o_mem_write, o_zero};
  endfunction

  function automatic exp_t mk_exp(input logic v, input logic [31:0] r, s, input logic [4:0] rd,
                                  input logic rw, mr, mw);
    return '{v, r, s, rd, rw, mr, mw, (v && (r == 32'd0))};
  endfunction

  function automatic logic [31:0] model_alu(input logic [5:0] op, input logic [31:0] a, b, rt,
                                            input logic [4:0] sa);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00, 6'h04: return rt << sa;
      6'h02: return rt >> sa;
      6'h03: return $signed(rt) >>> sa;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs();
    i_alu_op = 6'h0; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_rs_data = '0; i_rt_data = '0; i_imm = '0; i_shamt = '0;
    i_alu_src = 1'b0; i_shift_src = 1'b0;
    i_rs_addr = '0; i_rt_addr = '0; i_rd_addr = '0;
    i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_mem_fwd_we = 1'b0; i_wb_fwd_we = 1'b0; i_mem_fwd_addr = '0; i_wb_fwd_addr = '0;
    i_mem_fwd_data = '0; i_wb_fwd_data = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic vld, input logic [31:0] rs_d, rt_d, imm,
                       input logic [4:0] sh, input logic asrc, ssrc,
                       input logic [4:0] rs_a, rt_a, rd_a, input logic rw, mr, mw);
    i_alu_op = op; i_valid = vld; i_rs_data = rs_d; i_rt_data = rt_d; i_imm = imm;
    i_shamt = sh; i_alu_src = asrc; i_shift_src = ssrc;
    i_rs_addr = rs_a; i_rt_addr = rt_a; i_rd_addr = rd_a;
    i_reg_write = rw; i_mem_read = mr; i_mem_write = mw;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] ma, input logic [31:0] md,
                         input logic wwe, input logic [4:0] wa, input logic [31:0] wd);
    i_mem_fwd_we = mwe; i_mem_fwd_addr = ma; i_mem_fwd_data = md;
    i_wb_fwd_we = wwe; i_wb_fwd_addr = wa; i_wb_fwd_data = wd;
  endtask

  task automatic test_reset();
    exp_t e;
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (get_obs() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", get_obs());
    end
    @(negedge clock); reset = 1'b1;
    issue(6'h20, 1'b1, 32'd3, 32'd4, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd7, 32'd4, 5'd9, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL pre_reset_load: got %h expected %h", get_obs(), e); end
    #2 reset = 1'b0;
    #1; n_checks++;
    if (get_obs() !== exp_t'(0)) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0", get_obs());
    end
    @(posedge clock); #1; n_checks++;
    if (get_obs() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_held: got %h expected 0", get_obs());
    end
    @(negedge clock); reset = 1'b1;
    issue(6'h20, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd12, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1;
    e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL reset_release_add: got %h expected %h", get_obs(), e); end
  endtask

  task automatic test_forwarding();
    exp_t e;
    // MEM and WB both target rs: MEM wins -> 100 + 1
    @(negedge clock); clear_inputs();
    set_fwd(1'b1, 5'd3, 32'd100, 1'b1, 5'd3, 32'd200);
    issue(6'h20, 1'b1, 32'd50, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd101, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL fwd_mem_prio: got %h expected %h", get_obs(), e); end
    // Only WB matches
    @(negedge clock); i_mem_fwd_we = 1'b0;
    sb.push_back(mk_exp(1'b1, 32'd201, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL fwd_wb: got %h expected %h", get_obs(), e); end
    // Register 0 never forwarded
    @(negedge clock);
    set_fwd(1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200);
    issue(6'h20, 1'b1, 32'd50, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd51, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL fwd_reg0: got %h expected %h", get_obs(), e); end
    // rt forwarded from MEM feeds both ALU B and store data (SW)
    @(negedge clock);
    set_fwd(1'b1, 5'd6, 32'h0000_0040, 1'b1, 5'd6, 32'h0000_0999);
    issue(6'h20, 1'b1, 32'd2, 32'd77, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1);
    sb.push_back(mk_exp(1'b1, 32'h42, 32'h40, 5'd0, 1'b0, 1'b0, 1'b1));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL fwd_rt_store: got %h expected %h", get_obs(), e); end
  endtask

  task automatic test_shifts();
    exp_t e;
    logic [5:0]  ops [4]  = '{6'h03, 6'h02, 6'h04, 6'h00};
    logic        ssrc[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] rts [4]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    logic [31:0] exps[4]  = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0000, 32'h0000_0010};
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); clear_inputs();
      issue(ops[k], 1'b1, 32'd1, rts[k], 32'd0, 5'd4, 1'b0, ssrc[k], 5'd7, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0);
      sb.push_back(mk_exp(1'b1, exps[k], rts[k], 5'd10, 1'b1, 1'b0, 1'b0));
      @(posedge clock); #1; e = sb.pop_front(); n_checks++;
      if (get_obs() !== e) begin n_fail++; $display("FAIL shift_%0d: got %h expected %h", k, get_obs(), e); end
    end
  endtask

  task automatic test_slt_sub();
    exp_t e;
    logic [5:0]  ops [6] = '{6'h2a, 6'h2a, 6'h22, 6'h20, 6'h27, 6'h26};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'd1, 32'd9, 32'h10, 32'h0F0F_0000, 32'hFF00_FF00};
    logic [31:0] bs  [6] = '{32'd1, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFF0, 32'h0000_00F0, 32'h0F0F_0F0F};
    logic        imm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exps[6] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'hF0F0_FF0F, 32'hF00F_F00F};
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); clear_inputs();
      issue(ops[k], 1'b1, as[k], imm[k] ? 32'd3 : bs[k], imm[k] ? bs[k] : 32'd0, 5'd0, imm[k], 1'b0,
            5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0);
      sb.push_back(mk_exp(1'b1, exps[k], imm[k] ? 32'd3 : bs[k], 5'd11, 1'b1, 1'b0, 1'b0));
      @(posedge clock); #1; e = sb.pop_front(); n_checks++;
      if (get_obs() !== e) begin n_fail++; $display("FAIL alu_%0d: got %h expected %h", k, get_obs(), e); end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    @(negedge clock); clear_inputs();
    issue(6'h20, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd12, 32'd7, 5'd12, 1'b1, 1'b1, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL stall_load: got %h expected %h", get_obs(), e); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); i_stall = 1'b1;
      issue(6'h22, 1'b1, 32'd90 + k, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd20, 1'b0, 1'b0, 1'b1);
      set_fwd(1'b1, 5'd1, 32'd1000 + k, 1'b1, 5'd2, 32'd555);
      sb.push_back(mk_exp(1'b1, 32'd12, 32'd7, 5'd12, 1'b1, 1'b1, 1'b0));
      @(posedge clock); #1; e = sb.pop_front(); n_checks++;
      if (get_obs() !== e) begin n_fail++; $display("FAIL stall_hold_%0d: got %h expected %h", k, get_obs(), e); end
    end
    @(negedge clock); clear_inputs();
    issue(6'h22, 1'b1, 32'd20, 32'd5, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd15, 32'd5, 5'd13, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL stall_release: got %h expected %h", get_obs(), e); end
  endtask

  task automatic test_flush();
    exp_t e;
    @(negedge clock); clear_inputs();
    i_flush = 1'b1; i_stall = 1'b1;
    issue(6'h20, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    sb.push_back(exp_t'(0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL flush_over_stall: got %h expected %h", get_obs(), e); end
    @(negedge clock); i_flush = 1'b0; i_stall = 1'b0;
    issue(6'h3f, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd0, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL unknown_op: got %h expected %h", get_obs(), e); end
    @(negedge clock);
    issue(6'h20, 1'b0, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1);
    sb.push_back(exp_t'(0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL invalid_bubble: got %h expected %h", get_obs(), e); end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    @(negedge clock); clear_inputs();
    issue(6'h20, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd12, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL rms_load: got %h expected %h", get_obs(), e); end
    @(negedge clock); i_stall = 1'b1;
    #2 reset = 1'b0;
    #1; n_checks++;
    if (get_obs() !== exp_t'(0)) begin n_fail++; $display("FAIL rms_async: got %h expected 0", get_obs()); end
    @(negedge clock); reset = 1'b1;
    sb.push_back(exp_t'(0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL rms_hold_zero: got %h expected %h", get_obs(), e); end
    @(negedge clock); i_stall = 1'b0;
    issue(6'h20, 1'b1, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'd2, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1; e = sb.pop_front(); n_checks++;
    if (get_obs() !== e) begin n_fail++; $display("FAIL rms_resume: got %h expected %h", get_obs(), e); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0]  op_tbl [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2a, 6'h00, 6'h04, 6'h02, 6'h03, 6'h15};
    logic [31:0] rs_d, rt_d, imm, frs, frt, b, res;
    logic [4:0]  rs_a, rt_a, rd_a, sh, sa, ma, wa;
    logic [5:0]  op;
    logic        asrc, ssrc, mwe, wwe, vld, rw, mr, mw;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock); clear_inputs();
      op = op_tbl[$urandom_range(0, 11)];
      rs_d = $urandom; rt_d = $urandom; imm = $urandom; sh = 5'($urandom);
      rs_a = 5'($urandom_range(0, 3)); rt_a = 5'($urandom_range(0, 3)); rd_a = 5'($urandom);
      ma = 5'($urandom_range(0, 3)); wa = 5'($urandom_range(0, 3));
      mwe = 1'($urandom); wwe = 1'($urandom); asrc = 1'($urandom); ssrc = 1'($urandom);
      vld = ($urandom_range(0, 7) != 0); rw = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
      set_fwd(mwe, ma, 32'h1000_0000 + 32'(k), wwe, wa, 32'h2000_0000 + 32'(k));
      issue(op, vld, rs_d, rt_d, imm, sh, asrc, ssrc, rs_a, rt_a, rd_a, rw, mr, mw);
      frs = (mwe && ma == rs_a && rs_a != 0) ? i_mem_fwd_data :
            (wwe && wa == rs_a && rs_a != 0) ? i_wb_fwd_data : rs_d;
      frt = (mwe && ma == rt_a && rt_a != 0) ? i_mem_fwd_data :
            (wwe && wa == rt_a && rt_a != 0) ? i_wb_fwd_data : rt_d;
      b   = asrc ? imm : frt;
      sa  = ssrc ? frs[4:0] : sh;
      res = model_alu(op, frs, b, frt, sa);
      sb.push_back(vld ? mk_exp(1'b1, res, frt, rd_a, rw, mr, mw) : exp_t'(0));
      @(posedge clock); #1; e = sb.pop_front(); n_checks++;
      if (get_obs() !== e) begin
        n_fail++; $display("FAIL b2b_%0d op=%h: got %h expected %h", k, op, get_obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_shifts();
    test_slt_sub();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline: consumes the 6-bit ALU operation produced by the ALU-control decoder together with the decoded operands, resolves operand forwarding from MEM and WB, evaluates the ALU, and registers the result plus pass-through control into the EX/MEM pipeline register. Supports stall (hold) and flush (bubble insertion) driven by the hazard unit.

## Interface
- NB_DATA, 32, datapath width
- NB_REG, 5, register-address width
- NB_OP_ALU, 6, ALU operation code width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_alu_op  in  NB_OP_ALU  operation from ALU-control decoder
- i_valid  in  1  incoming instruction is real (0 = bubble)
- i_stall  in  1  hold EX/MEM register
- i_flush  in  1  load a bubble into EX/MEM
- i_rs_data, i_rt_data  in  NB_DATA  register-file read values
- i_imm  in  NB_DATA  immediate, already sign/zero-extended by decode
- i_shamt  in  NB_REG  instruction shamt field
- i_alu_src  in  1  operand B: 0 = rt, 1 = imm
- i_shift_src  in  1  shift amount: 0 = shamt, 1 = rs[4:0]
- i_rs_addr, i_rt_addr, i_rd_addr  in  NB_REG  sources; destination already selected
- i_reg_write, i_mem_read, i_mem_write  in  1  control to pass through
- i_mem_fwd_we, i_wb_fwd_we  in  1  MEM/WB will write a register
- i_mem_fwd_addr, i_wb_fwd_addr  in  NB_REG  their destinations
- i_mem_fwd_data, i_wb_fwd_data  in  NB_DATA  their values
- o_valid  out  1  EX/MEM holds a real instruction
- o_alu_result  out  NB_DATA  registered ALU result
- o_store_data  out  NB_DATA  registered forwarded rt (SW data)
- o_rd_addr  out  NB_REG  registered destination
- o_reg_write, o_mem_read, o_mem_write  out  1  registered control
- o_zero  out  1  registered (o_alu_result == 0)

## Operation
- Forwarding per source (rs, rt independently): MEM match if i_mem_fwd_we && addr == src && src != 0; else WB match under same rule; else register-file value. MEM has priority over WB. Register 0 never forwarded.
- Operand A = forwarded rs; operand B = i_alu_src ? i_imm : forwarded rt. Shift amount = i_shift_src ? fwd_rs[4:0] : i_shamt; shifted operand is forwarded rt.
- Ops: 100000 A+B; 100010 A−B; 100100 A&B; 100101 A|B; 100110 A^B; 100111 ~(A|B); 101010 signed A<B → 1 else 0; 000000 rt<<sa; 000100 rt<<sa; 000010 rt>>sa logical; 000011 rt>>sa arithmetic; any other code → 0.
- Arithmetic modulo 2^32; no overflow detection or trap (ADD/ADDU identical).
- Register update priority: reset > flush > stall > load.
  - flush: o_valid, o_reg_write, o_mem_read, o_mem_write ← 0; data fields ← 0.
  - stall (no flush): all outputs hold.
  - load: i_valid=0 loads as flush; i_valid=1 loads computed result, forwarded rt into o_store_data, control, o_valid=1.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Forwarding and ALU are combinational within the cycle; forwarding inputs sampled at the same edge as the instruction.
- Reset: all outputs 0 immediately on reset low, independent of clock; held until first edge after reset high.
- Flush and stall in same cycle: flush wins.
- Stall multi-cycle: outputs stable for every stalled cycle; forwarding values presented during the stall are ignored.
- Reset asserted mid-stall or mid-flush: outputs 0; no pending state survives.

## Test plan
- Reset: drive reset low mid-cycle with nonzero inputs → all outputs 0 asynchronously; release, op 100000 rs=5 rt=7 valid → next edge o_alu_result=12, o_valid=1.
- Forwarding: rs_addr=3, MEM fwd addr 3 data 100, WB fwd addr 3 data 200, rt=1, op ADD → result 101; repeat with rs_addr=0 and fwd addr 0 → uses i_rs_data.
- Shifts: rt=0x80000000, shamt=4, op 000011 → 0xF8000000; op 000010 → 0x08000000; shift_src=1 rs=1, op 000100 → 0x00000000 (bit lost).
- SLT/SUB: A=0xFFFFFFFF, B=1, op 101010 → 1, o_zero=0; A=B=9, op 100010 → 0, o_zero=1.
- Stall: load ADD=12, then i_stall=1 for 3 cycles with changing inputs → outputs stay 12 / valid 1.
- Flush priority: i_flush=1, i_stall=1, valid ADD with i_reg_write=1 → o_valid=0, o_reg_write=0, o_alu_result=0; unknown op 111111 valid → result 0, o_valid=1.
